// File: rtl/bandpower_frame_reader_pkg.sv
// Shared definitions for the bandpower frame reader.
//   PWR_W       : native bandpower sample width
//   state_e     : frame serialiser states
//   band_idx_w  : width of a band index for a given band count
//   clamp_pwr   : signed-to-unsigned clamp (negative -> 0) for widths up to 32 bits
package bandpower_frame_reader_pkg;

    localparam int unsigned PWR_W = 16;
    localparam int unsigned SEQ_W = 8;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    function automatic int unsigned band_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // v carries a w-bit signed value in its low bits; upper bits are ignored.
    function automatic logic [31:0] clamp_pwr(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return v[w-1] ? '0 : (v & mask);
    endfunction

endpackage

// File: rtl/bandpower_capture_slot.sv
// Single-band capture slot: holds the newest clamped result of one bandpower channel.
//   clk, rst_n : clock, synchronous active-low reset
//   power_in   : signed band power, valid when done_in=1
//   done_in    : 1-cycle result strobe
//   take       : frame transfer is copying this slot this cycle
//   value      : stored clamped power
//   pending    : slot holds a result not yet moved into a frame
//   overrun    : a result is overwriting an unconsumed one this cycle
module bandpower_capture_slot
    import bandpower_frame_reader_pkg::*;
#(
    parameter int unsigned W = PWR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] power_in,
    input  logic         done_in,
    input  logic         take,
    output logic [W-1:0] value,
    output logic         pending,
    output logic         overrun
);

    logic [W-1:0] value_q, value_d;
    logic         pending_q, pending_d;

    always_comb begin
        value_d   = value_q;
        pending_d = pending_q;
        if (done_in) begin
            // A strobe on the transfer cycle stays pending for the next frame.
            value_d   = W'(clamp_pwr(32'(power_in), W));
            pending_d = 1'b1;
        end else if (take) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            pending_q <= pending_d;
        end
    end

    assign value   = value_q;
    assign pending = pending_q;
    assign overrun = done_in & pending_q & ~take;

endmodule

// File: rtl/bandpower_frame_reader.sv
// Collects one result per bandpower channel into a frame and serialises it, one band per
// beat, over a valid/ready stream.
//   clk, rst_n  : clock, synchronous active-low reset
//   power_in    : NUM_BANDS signed samples, band b at [b*W +: W]
//   done_in     : per-band 1-cycle result strobes
//   m_valid/m_ready/m_data/m_band/m_last/m_seq : output stream (m_seq constant per frame)
//   pending     : capture slot occupancy
//   overrun_cnt : saturating count of cycles in which a pending capture was overwritten
module bandpower_frame_reader
    import bandpower_frame_reader_pkg::*;
#(
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned W         = PWR_W,
    parameter int unsigned OVR_W     = 8,
    localparam int unsigned BW       = band_idx_w(NUM_BANDS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BANDS*W-1:0] power_in,
    input  logic [NUM_BANDS-1:0]   done_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [W-1:0]           m_data,
    output logic [BW-1:0]          m_band,
    output logic                   m_last,
    output logic [SEQ_W-1:0]       m_seq,
    output logic [NUM_BANDS-1:0]   pending,
    output logic [OVR_W-1:0]       overrun_cnt
);

    state_e             state_q, state_d;
    logic [W-1:0]       cap_val [NUM_BANDS];
    logic [W-1:0]       frame_q [NUM_BANDS];
    logic [W-1:0]       frame_d [NUM_BANDS];
    logic [NUM_BANDS-1:0] ovr;
    logic               take;
    logic               m_valid_q, m_valid_d;
    logic [W-1:0]       m_data_q, m_data_d;
    logic [BW-1:0]      m_band_q, m_band_d, band_next;
    logic               m_last_q, m_last_d;
    logic [SEQ_W-1:0]   m_seq_q, m_seq_d;
    logic [OVR_W-1:0]   ovr_cnt_q, ovr_cnt_d;

    assign take = (state_q == StIdle) && (&pending);

    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_slot
        bandpower_capture_slot #(
            .W (W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .power_in (power_in[g*W +: W]),
            .done_in  (done_in[g]),
            .take     (take),
            .value    (cap_val[g]),
            .pending  (pending[g]),
            .overrun  (ovr[g])
        );
    end

    assign band_next = m_band_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_band_d  = m_band_q;
        m_last_d  = m_last_q;
        m_seq_d   = m_seq_q;
        ovr_cnt_d = ovr_cnt_q;

        // Several slots overrunning in one cycle count once.
        if ((|ovr) && (ovr_cnt_q != '1)) begin
            ovr_cnt_d = ovr_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (take) begin
                    frame_d   = cap_val;
                    state_d   = StSend;
                    m_valid_d = 1'b1;
                    m_band_d  = '0;
                    m_last_d  = (NUM_BANDS == 1);
                    m_data_d  = cap_val[0];
                end
            end
            StSend: begin
                if (m_valid_q && m_ready) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_seq_d   = m_seq_q + 1'b1;
                        state_d   = StIdle;
                    end else begin
                        m_band_d = band_next;
                        m_last_d = (band_next == BW'(NUM_BANDS - 1));
                        m_data_d = frame_q[band_next];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            for (int i = 0; i < NUM_BANDS; i++) begin
                frame_q[i] <= '0;
            end
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_band_q  <= '0;
            m_last_q  <= 1'b0;
            m_seq_q   <= '0;
            ovr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_band_q  <= m_band_d;
            m_last_q  <= m_last_d;
            m_seq_q   <= m_seq_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_band      = m_band_q;
    assign m_last      = m_last_q;
    assign m_seq       = m_seq_q;
    assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_bandpower_frame_reader.sv
module tb_bandpower_frame_reader;

    localparam int NB = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NB*W-1:0] power_in = '0;
    logic [NB-1:0]   done_in = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [W-1:0]    m_data;
    logic [1:0]      m_band;
    logic            m_last;
    logic [7:0]      m_seq;
    logic [NB-1:0]   pending;
    logic [7:0]      overrun_cnt;

    int        n_checks = 0;
    int        n_pass = 0;
    logic [7:0] exp_seq = '0;

    typedef struct packed {
        logic [63:0] pin;
        logic [63:0] pexp;
        logic        one_shot;
    } vec_t;

    vec_t vec [3];

    always #5 clk = ~clk;

    bandpower_frame_reader #(
        .NUM_BANDS (NB),
        .W         (W),
        .OVR_W     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .power_in    (power_in),
        .done_in     (done_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_band      (m_band),
        .m_last      (m_last),
        .m_seq       (m_seq),
        .pending     (pending),
        .overrun_cnt (overrun_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic strobe(input int b, input logic [15:0] v);
        power_in[b*W +: W] = v;
        done_in = 4'b0001 << b;
        step();
        done_in = '0;
    endtask

    task automatic fill(input logic [63:0] vals);
        for (int b = 0; b < NB; b++) strobe(b, vals[b*W +: W]);
    endtask

    // Waits (bounded) for a frame, then accepts all beats with m_ready held high.
    task automatic collect(input string tag, input logic [63:0] exp_data);
        int waits;
        waits = 0;
        m_ready = 1'b1;
        while (!m_valid && waits < 20) begin
            step();
            waits++;
        end
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        for (int b = 0; b < NB; b++) begin
            chk({tag, "_data"}, 32'(m_data), 32'(exp_data[b*W +: W]));
            chk({tag, "_band"}, 32'(m_band), 32'(b));
            chk({tag, "_last"}, 32'(m_last), (b == NB - 1) ? 32'd1 : 32'd0);
            chk({tag, "_seq"}, 32'(m_seq), 32'(exp_seq));
            chk({tag, "_beat_valid"}, 32'(m_valid), 32'd1);
            step();
        end
        chk({tag, "_idle_after"}, 32'(m_valid), 32'd0);
        exp_seq++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec[0] = '{pin: {16'd400, 16'd300, 16'd200, 16'd100},
                   pexp: {16'd400, 16'd300, 16'd200, 16'd100}, one_shot: 1'b0};
        vec[1] = '{pin: {16'd5, 16'hFFFF, 16'h8000, 16'h7FFF},
                   pexp: {16'd5, 16'd0, 16'd0, 16'd32767}, one_shot: 1'b1};
        vec[2] = '{pin: {16'h1234, 16'd1, 16'd0, 16'hFF9C},
                   pexp: {16'h1234, 16'd1, 16'd0, 16'd0}, one_shot: 1'b0};

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_band", 32'(m_band), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_seq", 32'(m_seq), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovr", 32'(overrun_cnt), 32'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        step();

        // Table-driven frames: separate strobes, single-cycle strobes, clamping
        for (int i = 0; i < 3; i++) begin
            if (vec[i].one_shot) begin
                power_in = vec[i].pin;
                done_in = '1;
                step();
                done_in = '0;
            end else begin
                fill(vec[i].pin);
            end
            chk("lat_pre_valid", 32'(m_valid), 32'd0);
            chk("lat_pre_pending", 32'(pending), 32'hF);
            step();
            chk("lat_post_valid", 32'(m_valid), 32'd1);
            chk("lat_post_pending", 32'(pending), 32'd0);
            collect("vec", vec[i].pexp);
        end

        // Back-pressure mid-frame
        fill({16'd44, 16'd33, 16'd22, 16'd11});
        step();
        chk("bp_beat0", 32'(m_data), 32'd11);
        step();
        m_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_hold_data", 32'(m_data), 32'd22);
            chk("bp_hold_band", 32'(m_band), 32'd1);
            chk("bp_hold_valid", 32'(m_valid), 32'd1);
            chk("bp_hold_seq", 32'(m_seq), 32'(exp_seq));
        end
        m_ready = 1'b1;
        step();
        chk("bp_resume_data2", 32'(m_data), 32'd33);
        chk("bp_resume_band2", 32'(m_band), 32'd2);
        step();
        chk("bp_resume_data3", 32'(m_data), 32'd44);
        chk("bp_resume_last", 32'(m_last), 32'd1);
        step();
        chk("bp_end_valid", 32'(m_valid), 32'd0);
        exp_seq++;

        // Strobe on the transfer cycle
        fill({16'd40, 16'd30, 16'd20, 16'd10});
        power_in[1*W +: W] = 16'd55;
        done_in = 4'b0010;
        step();
        done_in = '0;
        chk("xfer_valid", 32'(m_valid), 32'd1);
        chk("xfer_pending", 32'(pending), 32'h2);
        chk("xfer_ovr", 32'(overrun_cnt), 32'd0);
        collect("xfer_old", {16'd40, 16'd30, 16'd20, 16'd10});
        strobe(0, 16'd1);
        strobe(2, 16'd2);
        strobe(3, 16'd3);
        collect("xfer_new", {16'd3, 16'd2, 16'd55, 16'd1});
        chk("xfer_ovr_after", 32'(overrun_cnt), 32'd0);

        // Overrun: newest wins, counter saturates
        strobe(2, 16'd7);
        strobe(2, 16'd9);
        chk("ovr_one", 32'(overrun_cnt), 32'd1);
        strobe(0, 16'd1);
        strobe(1, 16'd2);
        strobe(3, 16'd3);
        collect("ovr_frame", {16'd3, 16'd9, 16'd2, 16'd1});
        strobe(0, 16'd77);
        for (int k = 0; k < 300; k++) strobe(0, 16'd77);
        chk("ovr_sat", 32'(overrun_cnt), 32'd255);
        strobe(1, 16'd5);
        strobe(2, 16'd6);
        strobe(3, 16'd7);
        collect("ovr_sat_frame", {16'd7, 16'd6, 16'd5, 16'd77});
        chk("ovr_sat_hold", 32'(overrun_cnt), 32'd255);

        // Reset mid-frame
        fill({16'd4, 16'd3, 16'd2, 16'd1});
        step();
        strobe(0, 16'd9);
        step();
        chk("mid_band", 32'(m_band), 32'd2);
        chk("mid_pending", 32'(pending), 32'h1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_seq", 32'(m_seq), 32'd0);
        chk("mid_rst_ovr", 32'(overrun_cnt), 32'd0);
        chk("mid_rst_band", 32'(m_band), 32'd0);
        rst_n = 1'b1;
        exp_seq = '0;
        fill({16'd8, 16'd7, 16'd6, 16'd5});
        collect("post_rst", {16'd8, 16'd7, 16'd6, 16'd5});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
